// File: rtl/apb_slave_mem.sv
// APB slave backed by a register-array memory with programmable wait states and error reporting.
// Build option: define APB_SLAVE_MEM_PSTRB_EN to honour pstrb byte lanes on writes.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no transfer in flight; waiting for a setup phase
// ST_WAIT   | transfer captured; wait-state down-counter running
// ST_RESP   | pready high; transfer completes on psel & penable
module apb_slave_mem #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned MEM_DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR     = 32'h0,
   parameter int unsigned WAIT_WIDTH    = 4
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [ADDRESS_WIDTH-1:0]  paddr,
   input  logic [DATA_WIDTH-1:0]     pwdata,
   input  logic [DATA_WIDTH/8-1:0]   pstrb,
   input  logic [WAIT_WIDTH-1:0]     wait_cfg,
   output logic                      pready,
   output logic [DATA_WIDTH-1:0]     prdata,
   output logic                      pslverr,
   output logic [7:0]                err_count
);

   localparam int unsigned NBYTES     = DATA_WIDTH / 8;
   localparam int unsigned OFF_W      = $clog2(NBYTES);
   localparam int unsigned IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [63:0] LO_ADDR    = 64'(BASE_ADDR);
   localparam logic [63:0] HI_ADDR    = LO_ADDR + (64'(MEM_DEPTH) * 64'(NBYTES));
   localparam logic [63:0] ALIGN_MASK = 64'(NBYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                               state;
   state_t                               state_nxt;
   logic [WAIT_WIDTH-1:0]                wait_cnt;
   logic [WAIT_WIDTH-1:0]                wait_cnt_nxt;

   logic [ADDRESS_WIDTH-1:0]             addr_q;
   logic                                 write_q;
   logic [DATA_WIDTH-1:0]                wdata_q;
   logic [DATA_WIDTH-1:0]                wmask;
   logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0] mem;

   logic                                 setup_hit;
   logic                                 complete;
   logic                                 entering_resp;
   logic [ADDRESS_WIDTH-1:0]             acc_addr;
   logic                                 acc_write;
   logic [63:0]                          addr_ext;
   logic [63:0]                          offset;
   logic                                 acc_err;
   logic [IDX_W-1:0]                     acc_idx;

   assign setup_hit     = (state == ST_IDLE) && psel && !penable;
   assign complete      = (state == ST_RESP) && psel && penable;
   assign entering_resp = (state != ST_RESP) && (state_nxt == ST_RESP);

   // With zero wait states RESP is entered on the setup edge itself, so the
   // decode must look at the live bus in IDLE and at the captured copy after.
   assign acc_addr  = (state == ST_IDLE) ? paddr  : addr_q;
   assign acc_write = (state == ST_IDLE) ? pwrite : write_q;
   assign addr_ext  = 64'(acc_addr);
   assign offset    = addr_ext - LO_ADDR;
   assign acc_idx   = IDX_W'(offset >> OFF_W);
   assign acc_err   = (addr_ext < LO_ADDR) || (addr_ext >= HI_ADDR) ||
                      ((addr_ext & ALIGN_MASK) != 64'd0);

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      unique case (state)
         ST_IDLE: begin
            if (psel && !penable) begin
               if (wait_cfg == '0) begin
                  state_nxt = ST_RESP;
               end else begin
                  state_nxt    = ST_WAIT;
                  wait_cnt_nxt = wait_cfg;
               end
            end
         end
         ST_WAIT: begin
            if (!psel) begin
               state_nxt    = ST_IDLE;
               wait_cnt_nxt = '0;
            end else if (wait_cnt <= WAIT_WIDTH'(1)) begin
               state_nxt    = ST_RESP;
               wait_cnt_nxt = '0;
            end else begin
               wait_cnt_nxt = wait_cnt - WAIT_WIDTH'(1);
            end
         end
         ST_RESP: begin
            if (!psel || penable) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else if (setup_hit) begin
         addr_q  <= paddr;
         write_q <= pwrite;
         wdata_q <= pwdata;
      end
   end

`ifdef APB_SLAVE_MEM_PSTRB_EN
   logic [NBYTES-1:0] strb_q;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         strb_q <= '0;
      end else if (setup_hit) begin
         strb_q <= pstrb;
      end
   end

   for (genvar b = 0; b < NBYTES; b++) begin : g_wmask
      assign wmask[8*b +: 8] = {8{strb_q[b]}};
   end
`else
   logic unused_pstrb;

   assign unused_pstrb = ^pstrb;
   assign wmask        = '1;
`endif

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
      end else begin
         pready <= (state_nxt == ST_RESP);
         if (entering_resp) begin
            pslverr <= acc_err;
         end else if (state_nxt != ST_RESP) begin
            pslverr <= 1'b0;
         end
         if (entering_resp && !acc_write) begin
            prdata <= acc_err ? '0 : mem[acc_idx];
         end
      end
   end

   // Writes commit only on the completing edge so an abort or reset leaves memory untouched.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         mem <= '0;
      end else if (complete && write_q && !acc_err) begin
         mem[acc_idx] <= (mem[acc_idx] & ~wmask) | (wdata_q & wmask);
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         err_count <= 8'd0;
      end else if (complete && acc_err && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: width of paddr, maximum 32.
REQ-002 Parameter DATA_WIDTH, default 32: width of pwdata and prdata, one of 8/16/32.
REQ-003 Parameter MEM_DEPTH, default 64: number of DATA_WIDTH-wide words held; power of two.
REQ-004 Parameter BASE_ADDR, default 0: byte address of word 0; aligned to DATA_WIDTH/8.
REQ-005 Parameter WAIT_WIDTH, default 4: width of wait_cfg.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 pclk  in  1  clock; all state updates on its rising edge.
REQ-008 preset  in  1  asynchronous active-high reset.
REQ-009 psel  in  1  slave select.
REQ-010 penable  in  1  access-phase indicator.
REQ-011 pwrite  in  1  1=write, 0=read.
REQ-012 paddr  in  ADDRESS_WIDTH  byte address.
REQ-013 pwdata  in  DATA_WIDTH  write data.
REQ-014 pstrb  in  DATA_WIDTH/8  byte-lane write strobes.
REQ-015 wait_cfg  in  WAIT_WIDTH  wait states inserted for the transfer; sampled in setup phase.
REQ-016 pready  out  1  registered ready.
REQ-017 prdata  out  DATA_WIDTH  registered read data.
REQ-018 pslverr  out  1  registered error; meaningful only while pready=1.
REQ-019 err_count  out  8  saturating count of completed error transfers.

Function
REQ-020 FSM states IDLE, WAIT, RESP; pready=1 only in RESP.
REQ-021 IDLE: psel=1, penable=0 -> capture paddr/pwrite/pwdata/pstrb/wait_cfg; wait_cfg=0 -> RESP, else WAIT with counter=wait_cfg.
REQ-022 WAIT: counter decrements each cycle; counter=1 -> RESP next edge; N wait states give pready high in cycle N+1 after setup cycle.
REQ-023 Zero wait states: pready high in the first access-phase cycle.
REQ-024 RESP: psel=1 and penable=1 -> transfer completes at that edge, return to IDLE; next setup may be presented in the following cycle.
REQ-025 Error when captured address < BASE_ADDR, >= BASE_ADDR+MEM_DEPTH*DATA_WIDTH/8, or not word-aligned.
REQ-026 Word index = (paddr-BASE_ADDR)/(DATA_WIDTH/8), truncated to log2(MEM_DEPTH) bits.
REQ-027 Read: prdata loaded with addressed word on the edge entering RESP; prdata=0 on error.
REQ-028 Write: memory updated on the completing edge only; no update on error.
REQ-029 pslverr set on edge entering RESP if error, cleared on leaving RESP.
REQ-030 err_count increments on completion of an error transfer; holds at 255.
REQ-031 psel=0 in WAIT or RESP (abort): return to IDLE next edge, no write, no err_count change.
REQ-032 Outside RESP: pready=0, pslverr=0, prdata holds last value.
REQ-033 penable=1 while in IDLE is ignored; no capture.

Reset
REQ-034 preset asserted: immediately pready=0, pslverr=0, prdata=0, err_count=0, FSM=IDLE, wait counter=0, all memory words=0.
REQ-035 Reset mid-transfer aborts it; no memory update occurs.
REQ-036 First transfer accepted on setup cycle after preset deasserts.

Configuration
REQ-037 Macro APB_SLAVE_MEM_PSTRB_EN defined: only byte lanes with pstrb[i]=1 written; other lanes retain contents.
REQ-038 Macro undefined: pstrb ignored; every non-error write updates full word.

Verification
REQ-039 Reset, write 0xDEADBEEF to 0x04 wait_cfg=0, read 0x04 -> pready in first access cycle, prdata=0xDEADBEEF, pslverr=0.
REQ-040 Read 0x04 with wait_cfg=3 -> pready low 3 access cycles, high in 4th, prdata=0xDEADBEEF.
REQ-041 Write 0x11223344 to 0x100 (MEM_DEPTH=64, BASE_ADDR=0) -> pslverr=1, err_count=1; read 0x100 -> pslverr=1, prdata=0, err_count=2.
REQ-042 PSTRB_EN defined: write 0xAABBCCDD pstrb=4'b0101 over 0x11223344 at 0x08 -> read 0x11BB33DD; undefined -> 0xAABBCCDD.
REQ-043 Write 0x55 to 0x0C wait_cfg=5, drop psel after 2 access cycles -> read 0x0C returns 0, err_count unchanged.
REQ-044 Assert preset during WAIT of write to 0x10 -> pready=0 immediately, read 0x10 after release returns 0.
